song_recorder: RTL and testbench
================================

SONG_RECORDER -- requirements
Module: song_recorder

Interface
REQ-001 Parameter DEPTH, default 32, event buffer entries, power of two, 2..256.
REQ-002 Parameter TICK_DIV, default 100000, clk cycles per duration tick (1 ms at 100 MHz).
REQ-003 Parameter DUR_W, default 16, duration field width in ticks.
REQ-004 clk  input  1  single system clock, all logic on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 key  input  4  debounced key code from key scanner, valid while key_on=1.
REQ-007 key_on  input  1  key held indicator.
REQ-008 rec_start  input  1  one-cycle pulse, clear buffer and arm recording.
REQ-009 rec_stop  input  1  one-cycle pulse, end recording.
REQ-010 rd_next  input  1  one-cycle pulse, request next stored event.
REQ-011 rd_rewind  input  1  one-cycle pulse, read pointer to 0.
REQ-012 rd_note  output  4  note code of last read event.
REQ-013 rd_dur  output  DUR_W  duration of last read event, ticks.
REQ-014 rd_valid  output  1  one-cycle pulse, rd_note/rd_dur updated.
REQ-015 rd_done  output  1  level, read pointer equals event count.
REQ-016 recording  output  1  high in WAIT_FIRST or CAPTURE.
REQ-017 event_count  output  log2(DEPTH)+1  events stored.
REQ-018 overflow  output  1  sticky, buffer filled during recording.

Function
REQ-019 FSM states IDLE, WAIT_FIRST, CAPTURE, DONE; reset state IDLE.
REQ-020 rec_start in any state: event_count, read pointer, overflow, tick counters cleared; next state WAIT_FIRST.
REQ-021 rec_start and rec_stop same cycle: rec_start wins.
REQ-022 WAIT_FIRST: on key_on=1, latch key as current note, duration=0, go CAPTURE; rec_stop goes DONE with zero events.
REQ-023 CAPTURE: prescaler counts 0..TICK_DIV-1; on wrap duration increments, saturating at 2^DUR_W-1.
REQ-024 Event closes when key changes, key_on falls, or rec_stop; closed event {note, duration} written at index event_count next cycle, event_count+1.
REQ-025 Events with duration 0 are discarded (not written); new event begins same cycle with duration and prescaler 0.
REQ-026 Write making event_count==DEPTH: overflow=1, state DONE, further input ignored.
REQ-027 rec_stop in CAPTURE: close current event per REQ-024/025, then DONE.
REQ-028 IDLE and DONE ignore key/key_on; reads permitted only in these states, rd_next/rd_rewind ignored while recording=1.
REQ-029 rd_next with pointer<event_count: rd_note/rd_dur/rd_valid registered one cycle later, pointer+1; pointer==event_count: no rd_valid, outputs hold.
REQ-030 rd_rewind and rd_next same cycle: rewind wins, no read.
REQ-031 Buffer storage is synchronous-read RAM, DEPTH x (4+DUR_W).

Reset
REQ-032 rst low: state IDLE, event_count 0, pointers 0, prescaler 0, rd_note 0, rd_dur 0, rd_valid 0, overflow 0, recording 0; rd_done 1 (0==0).
REQ-033 rst asserted mid-recording discards all events; buffer contents need not be cleared.

Configuration
REQ-034 Macro SONG_RECORDER_REST_EN defined: key_on=0 intervals in CAPTURE are recorded as rest events, note code 4'hF, timed and closed per REQ-023..025.
REQ-035 SONG_RECORDER_REST_EN undefined: CAPTURE with key_on=0 stops prescaler and duration; gaps not stored; next key_on=1 starts a new note.

Verification (TICK_DIV=4, DEPTH=4)
REQ-036 rec_start; key=3 held 12 cycles, release; rec_stop; rd_next -> rd_valid, rd_note=3, rd_dur=3, event_count=1.
REQ-037 Five distinct notes of 8 cycles each -> event_count=4, overflow=1, state DONE, 5th note absent.
REQ-038 REST_EN defined: key 2 for 8 cycles, 8 cycles off, key 5 for 8, rec_stop -> events {2,2},{F,2},{5,2}; undefined -> {2,2},{5,2}.
REQ-039 Key change to 7 after 2 cycles of key 1 -> key 1 event discarded (dur 0), only key 7 stored.
REQ-040 rst low during CAPTURE with 2 events -> event_count=0, recording=0, rd_done=1; rd_next gives no rd_valid.
REQ-041 rd_next while recording=1 and rd_rewind+rd_next same cycle -> no rd_valid either case; pointer 0.

Source files
------------

// File: rtl/song_recorder.sv
// Key-event recorder: captures {note, duration} events into a synchronous RAM and plays them back on request.
// Define SONG_RECORDER_REST_EN to also record key-released gaps as rest events (note 4'hF).
module song_recorder #(
  parameter int DEPTH    = 32,
  parameter int TICK_DIV = 100000,
  parameter int DUR_W    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [3:0]               key,
  input  logic                     key_on,
  input  logic                     rec_start,
  input  logic                     rec_stop,
  input  logic                     rd_next,
  input  logic                     rd_rewind,
  output logic [3:0]               rd_note,
  output logic [DUR_W-1:0]         rd_dur,
  output logic                     rd_valid,
  output logic                     rd_done,
  output logic                     recording,
  output logic [$clog2(DEPTH):0]   event_count,
  output logic                     overflow,
  output logic [1:0]               state_dbg
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [3:0] REST_NOTE = 4'hF;

  typedef enum logic [1:0] {IDLE, WAIT_FIRST, CAPTURE, DONE} state_t;
  state_t state, state_nx;

  logic [3:0]       cur_note;
  logic             cur_valid;
  logic             cur_rest;
  logic [DUR_W-1:0] cur_dur;
  logic [PW-1:0]    presc;
  logic [AW:0]      rd_ptr;
  logic [4+DUR_W-1:0] mem [DEPTH];

  logic             active, want_valid, want_rest, change;
  logic             close_ev, do_write, start_ev, count_en, full;
  logic [PW-1:0]    base_presc, presc_step;
  logic [DUR_W-1:0] base_dur, dur_step;
  logic             wrap;

  assign recording = (state == WAIT_FIRST) || (state == CAPTURE);
  assign rd_done   = (rd_ptr == event_count);
  assign state_dbg = state;

  // The event the inputs currently ask for; a difference from the running event closes it.
  always_comb begin
`ifdef SONG_RECORDER_REST_EN
    want_valid = key_on || (state == CAPTURE);
    want_rest  = !key_on;
`else
    want_valid = key_on;
    want_rest  = 1'b0;
`endif
    change = (want_valid != cur_valid) ||
             (want_valid && cur_valid &&
              ((want_rest != cur_rest) || (!want_rest && (key != cur_note))));
    active   = recording && !rec_start;
    close_ev = active && cur_valid && (change || rec_stop);
    do_write = close_ev && (cur_dur != '0);
    full     = do_write && (event_count == (AW+1)'(DEPTH - 1));
    start_ev = active && !rec_stop && want_valid && change;
    count_en = active && !rec_stop && want_valid;
  end

  // A new event counts its first cycle, so duration = floor(cycles / TICK_DIV).
  always_comb begin
    base_presc = start_ev ? '0 : presc;
    base_dur   = start_ev ? '0 : cur_dur;
    wrap       = (base_presc == PW'(TICK_DIV - 1));
    presc_step = wrap ? '0 : base_presc + PW'(1);
    dur_step   = (wrap && (base_dur != {DUR_W{1'b1}})) ? base_dur + DUR_W'(1) : base_dur;
  end

  always_comb begin
    state_nx = state;
    if (rec_start) begin
      state_nx = WAIT_FIRST;
    end else begin
      case (state)
        WAIT_FIRST: begin
          if (rec_stop)    state_nx = DONE;
          else if (key_on) state_nx = CAPTURE;
        end
        CAPTURE: begin
          if (rec_stop || full) state_nx = DONE;
        end
        default: state_nx = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) mem[event_count[AW-1:0]] <= {cur_note, cur_dur};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      event_count <= '0;
      rd_ptr      <= '0;
      presc       <= '0;
      cur_dur     <= '0;
      cur_note    <= '0;
      cur_valid   <= 1'b0;
      cur_rest    <= 1'b0;
      overflow    <= 1'b0;
      rd_note     <= '0;
      rd_dur      <= '0;
      rd_valid    <= 1'b0;
    end else begin
      state    <= state_nx;
      rd_valid <= 1'b0;
      if (rec_start) begin
        event_count <= '0;
        rd_ptr      <= '0;
        overflow    <= 1'b0;
        presc       <= '0;
        cur_dur     <= '0;
        cur_valid   <= 1'b0;
        cur_rest    <= 1'b0;
      end else begin
        if (do_write) begin
          event_count <= event_count + (AW+1)'(1);
          if (full) overflow <= 1'b1;
        end
        if (start_ev) begin
          cur_note  <= want_rest ? REST_NOTE : key;
          cur_rest  <= want_rest;
          cur_valid <= 1'b1;
        end else if (close_ev) begin
          cur_valid <= 1'b0;
        end
        if (count_en) begin
          presc   <= presc_step;
          cur_dur <= dur_step;
        end
        // rd_next is a one-cycle request; rd_valid pulses the cycle after it when an event was read.
        if (!recording) begin
          if (rd_rewind) begin
            rd_ptr <= '0;
          end else if (rd_next && (rd_ptr != event_count)) begin
            {rd_note, rd_dur} <= mem[rd_ptr[AW-1:0]];
            rd_valid          <= 1'b1;
            rd_ptr            <= rd_ptr + (AW+1)'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_song_recorder.sv
// Self-checking bench for song_recorder (DEPTH=4, TICK_DIV=4); honours SONG_RECORDER_REST_EN.
module tb_song_recorder;

  localparam int DEPTH    = 4;
  localparam int TICK_DIV = 4;
  localparam int DUR_W    = 16;
`ifdef SONG_RECORDER_REST_EN
  localparam bit REST_EN = 1'b1;
`else
  localparam bit REST_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [3:0] key = '0;
  logic key_on = 1'b0, rec_start = 1'b0, rec_stop = 1'b0, rd_next = 1'b0, rd_rewind = 1'b0;
  logic [3:0]       rd_note;
  logic [DUR_W-1:0] rd_dur;
  logic             rd_valid, rd_done, recording, overflow;
  logic [2:0]       event_count;
  logic [1:0]       state_dbg;

  int checks = 0;
  int failures = 0;
  int n_exp = 0;
  logic [19:0] exp_q[$];
  logic [19:0] last_rd = '0;

  typedef struct {
    logic       on;
    logic [3:0] k;
    int         cycles;
    int         exp_dur;   // expected stored duration, 0 = not stored
    bit         last;
  } seg_t;
  seg_t tbl[13];

  song_recorder #(.DEPTH(DEPTH), .TICK_DIV(TICK_DIV), .DUR_W(DUR_W)) dut (
    .clk(clk), .rst(rst), .key(key), .key_on(key_on), .rec_start(rec_start),
    .rec_stop(rec_stop), .rd_next(rd_next), .rd_rewind(rd_rewind),
    .rd_note(rd_note), .rd_dur(rd_dur), .rd_valid(rd_valid), .rd_done(rd_done),
    .recording(recording), .event_count(event_count), .overflow(overflow),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // driver tasks: each starts and ends at a falling edge
  task automatic start_rec();
    rec_start = 1'b1;
    @(negedge clk);
    rec_start = 1'b0;
    n_exp = 0;
  endtask

  task automatic stop_rec();
    key_on = 1'b0;
    rec_stop = 1'b1;
    @(negedge clk);
    rec_stop = 1'b0;
  endtask

  task automatic run_seg(input seg_t s);
    key_on = s.on;
    if (s.on) key = s.k;
    repeat (s.cycles) @(negedge clk);
    if (s.exp_dur != 0 && (s.on || REST_EN)) begin
      exp_q.push_back({(s.on ? s.k : 4'hF), 16'(s.exp_dur)});
      n_exp++;
    end
  endtask

  task automatic pulse_next();
    rd_next = 1'b1;
    @(negedge clk);
    rd_next = 1'b0;
  endtask

  // scoreboard: rewind, pop every expected event, then probe past the end
  task automatic read_all();
    logic [19:0] e;
    bit got;
    rd_rewind = 1'b1;
    @(negedge clk);
    rd_rewind = 1'b0;
    check("rd_done_after_rewind", 32'(rd_done), 32'(exp_q.size() == 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      pulse_next();
      got = 1'b0;
      for (int i = 0; i < 4 && !got; i++) begin
        if (rd_valid) got = 1'b1;
        else @(negedge clk);
      end
      check("rd_valid", 32'(got), 32'd1);
      check("rd_event", 32'({rd_note, rd_dur}), 32'(e));
      last_rd = e;
    end
    check("rd_done_end", 32'(rd_done), 32'd1);
    pulse_next();
    check("rd_valid_past_end", 32'(rd_valid), 32'd0);
    @(negedge clk);
    check("rd_valid_past_end2", 32'(rd_valid), 32'd0);
    check("rd_hold", 32'({rd_note, rd_dur}), 32'(last_rd));
  endtask

  initial begin
    tbl[0]  = '{1'b1, 4'd3,  12, 3, 1'b0};
    tbl[1]  = '{1'b0, 4'd0,  1,  0, 1'b1};
    tbl[2]  = '{1'b1, 4'd2,  8,  2, 1'b0};
    tbl[3]  = '{1'b0, 4'd0,  8,  2, 1'b0};
    tbl[4]  = '{1'b1, 4'd5,  8,  2, 1'b1};
    tbl[5]  = '{1'b1, 4'd1,  2,  0, 1'b0};
    tbl[6]  = '{1'b1, 4'd7,  9,  2, 1'b1};
    tbl[7]  = '{1'b0, 4'd0,  5,  0, 1'b0};
    tbl[8]  = '{1'b1, 4'd4,  5,  1, 1'b0};
    tbl[9]  = '{1'b1, 4'd9,  3,  0, 1'b0};
    tbl[10] = '{1'b1, 4'd10, 16, 4, 1'b0};
    tbl[11] = '{1'b0, 4'd0,  3,  0, 1'b0};
    tbl[12] = '{1'b1, 4'd6,  4,  1, 1'b1};

    repeat (3) @(negedge clk);
    check("rst_state", 32'(state_dbg), 32'd0);
    check("rst_count", 32'(event_count), 32'd0);
    check("rst_recording", 32'(recording), 32'd0);
    check("rst_rd_done", 32'(rd_done), 32'd1);
    check("rst_rd_out", 32'({rd_valid, rd_note, rd_dur}), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // table-driven recordings
    start_rec();
    for (int i = 0; i < 13; i++) begin
      run_seg(tbl[i]);
      if (tbl[i].last) begin
        stop_rec();
        check("rec_count", 32'(event_count), 32'(n_exp));
        check("rec_overflow", 32'(overflow), 32'd0);
        check("rec_state_done", 32'(state_dbg), 32'd3);
        check("rec_recording", 32'(recording), 32'd0);
        read_all();
        if (i < 12) start_rec();
      end
    end

    // overflow: five notes, fifth must not be stored
    start_rec();
    for (int k = 1; k <= 5; k++) begin
      seg_t s;
      s = '{1'b1, 4'(k), 8, (k <= 4) ? 2 : 0, 1'b0};
      run_seg(s);
    end
    check("ovf_state", 32'(state_dbg), 32'd3);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_count", 32'(event_count), 32'd4);
    stop_rec();
    check("ovf_count_after_stop", 32'(event_count), 32'd4);
    read_all();

    // rec_start and rec_stop together: start wins; stop in WAIT_FIRST gives zero events
    rec_start = 1'b1;
    rec_stop = 1'b1;
    @(negedge clk);
    rec_start = 1'b0;
    rec_stop = 1'b0;
    check("start_wins_state", 32'(state_dbg), 32'd1);
    check("start_wins_rec", 32'(recording), 32'd1);
    check("start_clears_ovf", 32'(overflow), 32'd0);
    stop_rec();
    check("wait_stop_state", 32'(state_dbg), 32'd3);
    check("wait_stop_count", 32'(event_count), 32'd0);

    // asynchronous reset mid-capture discards events
    start_rec();
    run_seg('{1'b1, 4'd1, 8, 2, 1'b0});
    run_seg('{1'b1, 4'd2, 8, 2, 1'b0});
    run_seg('{1'b1, 4'd3, 4, 0, 1'b0});
    check("pre_rst_count", 32'(event_count), 32'd2);
    check("pre_rst_state", 32'(state_dbg), 32'd2);
    exp_q.delete();
    #1 rst = 1'b0;
    #1;
    check("async_rst_count", 32'(event_count), 32'd0);
    check("async_rst_rec", 32'(recording), 32'd0);
    check("async_rst_done", 32'(rd_done), 32'd1);
    key_on = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    last_rd = '0;
    @(negedge clk);
    pulse_next();
    check("post_rst_no_valid", 32'(rd_valid), 32'd0);
    check("post_rst_rd_out", 32'({rd_note, rd_dur}), 32'd0);

    // reads ignored while recording; rewind beats next
    start_rec();
    pulse_next();
    check("rd_in_wait_first", 32'(rd_valid), 32'd0);
    run_seg('{1'b1, 4'd8, 8, 2, 1'b0});
    rd_next = 1'b1;
    run_seg('{1'b1, 4'd11, 4, 1, 1'b0});
    rd_next = 1'b0;
    check("rd_in_capture", 32'(rd_valid), 32'd0);
    stop_rec();
    rd_next = 1'b1;
    rd_rewind = 1'b1;
    @(negedge clk);
    rd_next = 1'b0;
    rd_rewind = 1'b0;
    check("rewind_wins", 32'(rd_valid), 32'd0);
    check("rewind_ptr0_done", 32'(rd_done), 32'd0);
    read_all();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
